// File: rtl/sys_defs.sv
// Shared fixed-point types and constants for the attention softmax datapath.
//   SCORE_QT      signed Q4.3 scaled score
//   V_QT          signed 8-bit V element; V_VECTOR_T is a full-width V row
//   EXP_ARG_QT    unsigned Q5.3 argument of exp_neg (non-negative score delta)
//   EXP_QT        unsigned Q1.7 exp_neg result (128 == 1.0)
//   LSUM_QT       unsigned Q9.7 softmax denominator
//   OACC_QT       signed 24-bit, 7 frac bits, output accumulator element
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 256
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 64
`endif

package sys_defs;
  localparam int unsigned EXP_FRAC = 7;

  typedef logic signed [7:0]  SCORE_QT;
  typedef logic signed [7:0]  V_QT;
  typedef logic        [7:0]  EXP_ARG_QT;
  typedef logic        [7:0]  EXP_QT;
  typedef logic        [15:0] LSUM_QT;
  typedef logic signed [23:0] OACC_QT;

  typedef V_QT    [`MAX_EMBEDDING_DIM-1:0] V_VECTOR_T;
  typedef OACC_QT [`MAX_EMBEDDING_DIM-1:0] OACC_VECTOR_T;

  localparam EXP_QT EXP_ONE = 8'd128;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;
endpackage

// File: rtl/exp_neg_approx.sv
// Combinational piecewise-linear approximation of exp(-x), x >= 0.
//   x : unsigned Q5.3 argument
//   y : unsigned Q1.7 result; y(0) == 128 exactly, 0 once the exponent reaches 8
module exp_neg_approx
  import sys_defs::*;
(
  input  EXP_ARG_QT x,
  output EXP_QT     y
);

  logic [9:0] t;
  logic [6:0] n;
  logic [2:0] f;
  EXP_QT      mant;

  always_comb begin
    // t ~= x * log2(e) using 1 + 1/2 - 1/16
    t    = {2'b00, x} + {3'b000, x[7:1]} - {6'b000000, x[7:4]};
    n    = t[9:3];
    f    = t[2:0];
    mant = EXP_ONE - EXP_QT'({f, 3'b000});
    y    = (n >= 7'd8) ? '0 : (mant >> n[2:0]);
  end

endmodule

// File: rtl/online_softmax_accum.sv
// Online-softmax (FlashAttention) accumulator for one query row at a time.
// Keeps running max m, denominator l and unnormalised output O over SEQ_LEN
// keys, then presents O/l to the normaliser with valid/ready.
//   clk, rst          clock, synchronous active-high reset
//   vld_in / rdy_out  upstream handshake for s_in (score) and v_in (V row)
//   vld_out / rdy_in  downstream handshake for o_out and l_out
module online_softmax_accum
  import sys_defs::*;
#(
  parameter int unsigned SEQ_LEN = `MAX_SEQ_LENGTH,
  parameter int unsigned DIM     = `MAX_EMBEDDING_DIM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_in,
  output logic                 rdy_out,
  input  SCORE_QT              s_in,
  input  V_QT    [DIM-1:0]     v_in,
  output logic                 vld_out,
  input  logic                 rdy_in,
  output OACC_QT [DIM-1:0]     o_out,
  output LSUM_QT               l_out
);

  localparam int unsigned     CNT_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  SCORE_QT             m_q, m_d;
  LSUM_QT              l_q, l_d;
  OACC_QT [DIM-1:0]    o_q, o_d;
  logic                s1_vld_q, s1_vld_d;
  EXP_QT               alpha_q, alpha_d, p_q, p_d;
  V_QT    [DIM-1:0]    v_q, v_d;

  logic                accept, last_elem, out_fire;
  SCORE_QT             m_max;
  EXP_ARG_QT           alpha_arg, p_arg;
  EXP_QT               alpha_exp, p_exp;
  logic        [23:0]  l_prod;
  logic signed [32:0]  o_prod [DIM];
  logic signed [16:0]  pv     [DIM];

  assign accept    = vld_in & rdy_out;
  assign last_elem = (cnt_q == CNT_LAST);
  assign out_fire  = vld_out & rdy_in;

  // Differences are known to lie in [0, 255], so the 8-bit wrap is exact.
  assign m_max     = (s_in > m_q) ? s_in : m_q;
  assign alpha_arg = EXP_ARG_QT'(m_max - m_q);
  assign p_arg     = EXP_ARG_QT'(m_max - s_in);

  exp_neg_approx u_exp_alpha (.x(alpha_arg), .y(alpha_exp));
  exp_neg_approx u_exp_p     (.x(p_arg),     .y(p_exp));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && last_elem) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (rdy_in) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    rdy_out = (state_q == ACCUM);
    vld_out = (state_q == OUT);
  end

  always_comb begin
    cnt_d    = cnt_q;
    m_d      = m_q;
    l_d      = l_q;
    o_d      = o_q;
    alpha_d  = alpha_q;
    p_d      = p_q;
    v_d      = v_q;
    s1_vld_d = accept;
    l_prod   = {8'b0, l_q} * {16'b0, alpha_q};
    for (int unsigned i = 0; i < DIM; i++) begin
      o_prod[i] = $signed({{9{o_q[i][23]}}, o_q[i]}) * $signed({25'b0, alpha_q});
      pv[i]     = $signed({1'b0, p_q}) * $signed({v_q[i][7], v_q[i]});
    end

    // Stage 1: rescale factor and weight for the incoming key
    if (accept) begin
      cnt_d = last_elem ? '0 : cnt_q + 1'b1;
      v_d   = v_in;
      if (cnt_q == '0) begin
        m_d     = s_in;
        alpha_d = '0;
        p_d     = EXP_ONE;
      end else begin
        m_d     = m_max;
        alpha_d = alpha_exp;
        p_d     = p_exp;
      end
    end

    // Stage 2: rescale the running sums and add the new contribution
    if (s1_vld_q) begin
      l_d = LSUM_QT'(l_prod >> EXP_FRAC) + LSUM_QT'(p_q);
      for (int unsigned i = 0; i < DIM; i++) begin
        o_d[i] = OACC_QT'(o_prod[i] >>> EXP_FRAC) + {{7{pv[i][16]}}, pv[i]};
      end
    end

    if (out_fire) begin
      cnt_d = '0;
      m_d   = '0;
      l_d   = '0;
      o_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      m_q      <= '0;
      l_q      <= '0;
      o_q      <= '0;
      s1_vld_q <= 1'b0;
      alpha_q  <= '0;
      p_q      <= '0;
      v_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      l_q      <= l_d;
      o_q      <= o_d;
      s1_vld_q <= s1_vld_d;
      alpha_q  <= alpha_d;
      p_q      <= p_d;
      v_q      <= v_d;
    end
  end

  assign o_out = o_q;
  assign l_out = l_q;

endmodule

// File: tb/tb_online_softmax_accum.sv
// Scoreboard bench for online_softmax_accum: directed rows, backpressure,
// mid-row / in-OUT reset and randomized rows against a behavioural model.
`timescale 1ns/1ps
module tb_online_softmax_accum;
  import sys_defs::*;

  localparam int unsigned SEQ  = 2;
  localparam int unsigned DIMT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld_in = 1'b0;
  logic rdy_in = 1'b1;
  logic rdy_out, vld_out;
  SCORE_QT              s_in = '0;
  V_QT    [DIMT-1:0]    v_in = '0;
  OACC_QT [DIMT-1:0]    o_out;
  LSUM_QT               l_out;
  EXP_ARG_QT            ex_x = '0;
  EXP_QT                ex_y;

  int n_cmp = 0;
  int n_bad = 0;
  int bp_mode = 0;  // 0 always ready, 1 never ready, 2 random

  typedef struct { int l; int o[DIMT]; } exp_t;
  exp_t sb[$];

  int rs [SEQ];
  int rv [SEQ][DIMT];

  always #5 clk = ~clk;

  online_softmax_accum #(.SEQ_LEN(SEQ), .DIM(DIMT)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .s_in(s_in), .v_in(v_in), .vld_out(vld_out), .rdy_in(rdy_in),
    .o_out(o_out), .l_out(l_out)
  );

  exp_neg_approx u_exp_unit (.x(ex_x), .y(ex_y));

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rdy_in = 1'b1;
      1:       rdy_in = 1'b0;
      default: rdy_in = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT offers a result, compare against the head.
  always @(negedge clk) begin
    if (!rst && vld_out) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got vld_out=1, expected no pending row (t=%0t)", $time);
      end else begin
        chk("rdy_out_in_out", int'(rdy_out), 0);
        chk("l_out", int'(l_out), sb[0].l);
        for (int i = 0; i < DIMT; i++)
          chk($sformatf("o_out[%0d]", i), int'($signed(o_out[i])), sb[0].o[i]);
        if (rdy_in) void'(sb.pop_front());
      end
    end
  end

  function automatic int exp_ref(input int x);
    int t, n, f;
    t = x + x / 2 - x / 16;
    n = t / 8;
    f = t % 8;
    return (n >= 8) ? 0 : ((128 - 8 * f) >> n);
  endfunction

  function automatic exp_t model(input int s[SEQ], input int v[SEQ][DIMT]);
    exp_t   e;
    longint o [DIMT];
    int     m, l, a, p, mn;
    m = 0; l = 0;
    for (int i = 0; i < DIMT; i++) o[i] = 0;
    for (int k = 0; k < SEQ; k++) begin
      if (k == 0) begin
        mn = s[k]; a = 0; p = 128;
      end else begin
        mn = (s[k] > m) ? s[k] : m;
        a  = exp_ref(mn - m);
        p  = exp_ref(mn - s[k]);
      end
      m = mn;
      l = ((l * a) >> 7) + p;
      for (int i = 0; i < DIMT; i++) o[i] = ((o[i] * a) >>> 7) + p * v[k][i];
    end
    e.l = l;
    for (int i = 0; i < DIMT; i++) e.o[i] = int'(o[i]);
    return e;
  endfunction

  task automatic send_elem(input int s, input int v[DIMT]);
    bit done = 1'b0;
    vld_in = 1'b1;
    s_in   = SCORE_QT'(s);
    for (int i = 0; i < DIMT; i++) v_in[i] = V_QT'(v[i]);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (rdy_out) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    vld_in = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got rdy_out stuck low, expected acceptance within 200 cycles");
    end
  endtask

  task automatic send_row(input exp_t e, input bit gaps);
    int vk [DIMT];
    for (int k = 0; k < SEQ; k++) begin
      if (k == SEQ - 1) sb.push_back(e);
      for (int i = 0; i < DIMT; i++) vk[i] = rv[k][i];
      send_elem(rs[k], vk);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d rows pending, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic set_row2(input int s0, input int s1, input int v0, input int v1);
    rs[0] = s0; rs[1] = s1;
    for (int i = 0; i < DIMT; i++) begin rv[0][i] = v0; rv[1][i] = v1; end
  endtask

  function automatic exp_t const_exp(input int l, input int o);
    exp_t e;
    e.l = l;
    for (int i = 0; i < DIMT; i++) e.o[i] = o;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    exp_t e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_vld_out", int'(vld_out), 0);
    chk("reset_rdy_out", int'(rdy_out), 1);
    chk("reset_l_out", int'(l_out), 0);
    chk("reset_o_out0", int'($signed(o_out[0])), 0);

    ex_x = 8'd0;   #1 chk("exp_neg(0)", int'(ex_y), 128);
    ex_x = 8'd8;   #1 chk("exp_neg(8)", int'(ex_y), 48);
    ex_x = 8'd16;  #1 chk("exp_neg(16)", int'(ex_y), 18);
    ex_x = 8'd255; #1 chk("exp_neg(255)", int'(ex_y), 0);
    @(posedge clk); #1;

    // Equal scores, unit V; also check output latency
    bp_mode = 0;
    set_row2(0, 0, 1, 1);
    send_row(const_exp(256, 256), 1'b0);
    @(negedge clk) chk("latency_c1_vld_out", int'(vld_out), 0);
    @(negedge clk) chk("latency_c2_vld_out", int'(vld_out), 1);
    drain();

    // Rising max with downstream stalled for 10 cycles
    bp_mode = 1;
    @(posedge clk); #1;
    set_row2(0, 8, 2, 0);
    send_row(const_exp(176, 96), 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = vld_out; end
    chk("bp_vld_out_rise", int'(seen), 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_vld_out_held", int'(vld_out), 1);
      chk("bp_rdy_out_low", int'(rdy_out), 0);
    end
    bp_mode = 0;
    drain();

    // Falling score, three rows in a row with random backpressure
    bp_mode = 2;
    set_row2(8, 0, 1, 1);
    repeat (3) send_row(const_exp(176, 176), 1'b0);
    bp_mode = 0;
    drain();

    // Reset after the first element of a row
    rs[0] = 50;
    for (int i = 0; i < DIMT; i++) rv[0][i] = 7;
    begin
      int vk [DIMT];
      for (int i = 0; i < DIMT; i++) vk[i] = rv[0][i];
      send_elem(rs[0], vk);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrow_rst_vld_out", int'(vld_out), 0);
    chk("midrow_rst_rdy_out", int'(rdy_out), 1);
    chk("midrow_rst_l_out", int'(l_out), 0);
    @(posedge clk); #1;
    set_row2(-20, 30, 5, -3);
    send_row(model(rs, rv), 1'b0);
    drain();

    // Reset while holding a result in OUT: that row must be discarded
    bp_mode = 1;
    @(posedge clk); #1;
    set_row2(10, 12, 9, 9);
    send_row(model(rs, rv), 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = vld_out; end
    chk("out_rst_vld_out_rise", int'(seen), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    chk("out_rst_vld_out", int'(vld_out), 0);
    chk("out_rst_rdy_out", int'(rdy_out), 1);
    bp_mode = 0;
    @(posedge clk); #1;

    // Randomized rows
    bp_mode = 2;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < SEQ; k++) begin
        rs[k] = $urandom_range(0, 255) - 128;
        for (int i = 0; i < DIMT; i++) rv[k][i] = $urandom_range(0, 255) - 128;
      end
      e = model(rs, rv);
      send_row(e, 1'b1);
    end
    bp_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
